// File: rtl/data_memory_pkg.sv
// Shared types and constants for the pipelined MEM-stage data memory.
package data_memory_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 6;
  localparam int unsigned LATENCY_MAX    = 15;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter for memory wait states: loads N, counts to zero, flags the 1->0 edge.
module mem_wait_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load on accept, otherwise decrement until empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // High during the cycle whose closing edge takes the count from 1 to 0.
  assign done = (count == WIDTH'(1)) && !load;

endmodule

// File: rtl/pipelined_data_memory.sv
// Word-addressed data memory with byte enables and programmable wait states.
module pipelined_data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LATENCY    = 0
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    MemoryRead,
  input  logic                    MemoryWrite,
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  input  logic [DATA_WIDTH/8-1:0] ByteEnable,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    ReadValid,
  output logic                    Busy
);

  localparam int unsigned NBYTES   = DATA_WIDTH / 8;
  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam bit          HAS_WAIT = (LATENCY != 0);

  // Reject unsupported parameterisations at elaboration.
  if ((DATA_WIDTH % 8) != 0 || LATENCY > LATENCY_MAX) begin : g_param_check
    $error("pipelined_data_memory: bad DATA_WIDTH or LATENCY");
  end

  mem_state_e            state;
  logic                  accept;
  logic                  complete;
  logic                  eff_rd;
  logic                  eff_wr;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [DATA_WIDTH-1:0] eff_wdata;
  logic [NBYTES-1:0]     eff_be;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Requests are only taken in IDLE and never while Reset is high.
  assign accept = !Reset && (state == IDLE) && (MemoryRead || MemoryWrite);

  if (!HAS_WAIT) begin : g_nowait
    // Zero wait states: the access completes on its accept edge.
    assign complete  = accept;
    assign eff_rd    = MemoryRead;
    assign eff_wr    = MemoryWrite;
    assign eff_addr  = Address;
    assign eff_wdata = WriteData;
    assign eff_be    = ByteEnable;
  end else begin : g_wait
    localparam int unsigned CW = $clog2(LATENCY + 1);

    logic                  cnt_done;
    logic                  cap_rd;
    logic                  cap_wr;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [NBYTES-1:0]     cap_be;

    mem_wait_counter #(.WIDTH(CW)) u_wait_counter (
      .clk        (Clock),
      .reset      (Reset),
      .load       (accept),
      .load_value (CW'(LATENCY)),
      .done       (cnt_done)
    );

    // Hold the accepted request so the pipeline inputs are free during WAIT.
    always_ff @(posedge Clock) begin
      if (accept) begin
        cap_rd    <= MemoryRead;
        cap_wr    <= MemoryWrite;
        cap_addr  <= Address;
        cap_wdata <= WriteData;
        cap_be    <= ByteEnable;
      end
    end

    assign complete  = !Reset && (state == WAIT) && cnt_done;
    assign eff_rd    = cap_rd;
    assign eff_wr    = cap_wr;
    assign eff_addr  = cap_addr;
    assign eff_wdata = cap_wdata;
    assign eff_be    = cap_be;
  end

  // Commit enabled byte lanes at completion; contents survive reset.
  always_ff @(posedge Clock) begin
    if (complete && eff_wr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (eff_be[i]) begin
          mem[eff_addr][8*i +: 8] <= eff_wdata[8*i +: 8];
        end
      end
    end
  end

  // Access FSM with registered read result, valid pulse and stall flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      ReadValid <= 1'b0;
      ReadData  <= '0;
    end else begin
      ReadValid <= 1'b0;
      if (complete && eff_rd) begin
        ReadData  <= mem[eff_addr];
        ReadValid <= 1'b1;
      end
      if (state == IDLE) begin
        if (accept && HAS_WAIT) begin
          state <= WAIT;
          Busy  <= 1'b1;
        end
      end else begin
        if (complete) begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Directed bench: one memory instance per latency under test, all sharing stimulus.
module tb_pipelined_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic [31:0] rdata0, rdata2, rdata3, rdata4;
  logic        rv0, rv2, rv3, rv4;
  logic        busy0, busy2, busy3, busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .LATENCY(0)) u_l0 (
    .Clock(clk), .Reset(reset), .MemoryRead(rd), .MemoryWrite(wr), .Address(addr),
    .WriteData(wdata), .ByteEnable(be), .ReadData(rdata0), .ReadValid(rv0), .Busy(busy0));
  pipelined_data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .LATENCY(2)) u_l2 (
    .Clock(clk), .Reset(reset), .MemoryRead(rd), .MemoryWrite(wr), .Address(addr),
    .WriteData(wdata), .ByteEnable(be), .ReadData(rdata2), .ReadValid(rv2), .Busy(busy2));
  pipelined_data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .LATENCY(3)) u_l3 (
    .Clock(clk), .Reset(reset), .MemoryRead(rd), .MemoryWrite(wr), .Address(addr),
    .WriteData(wdata), .ByteEnable(be), .ReadData(rdata3), .ReadValid(rv3), .Busy(busy3));
  pipelined_data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .LATENCY(4)) u_l4 (
    .Clock(clk), .Reset(reset), .MemoryRead(rd), .MemoryWrite(wr), .Address(addr),
    .WriteData(wdata), .ByteEnable(be), .ReadData(rdata4), .ReadValid(rv4), .Busy(busy4));

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic req(input logic r, input logic w, input int a, input logic [31:0] d,
                     input logic [3:0] b);
    rd    = r;
    wr    = w;
    addr  = 6'(a);
    wdata = d;
    be    = b;
  endtask

  task automatic idle(input int n);
    rd = 1'b0;
    wr = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    req(1'b1, 1'b0, 5, 32'h0, 4'h0);
    step();

    // Reset, then read (request during reset must be ignored).
    step();
    check("rst_rdata", rdata0, 32'h0);
    check("rst_rvalid", 32'(rv0), 32'h0);
    check("rst_busy4", 32'(busy4), 32'h0);
    rd = 1'b0;
    step();
    check("rst_rvalid2", 32'(rv0), 32'h0);
    reset = 1'b0;
    req(1'b1, 1'b0, 5, 32'h0, 4'h0);
    step();
    check("rd5_rvalid", 32'(rv0), 32'h1);
    check("rd5_busy0", 32'(busy0), 32'h0);
    check("rd5_busy3", 32'(busy3), 32'h1);
    rd = 1'b0;
    step();
    check("rd5_pulse", 32'(rv0), 32'h0);
    idle(6);

    // Byte-enabled writes at zero latency.
    req(1'b0, 1'b1, 3, 32'hAABBCCDD, 4'b1111); step();
    req(1'b0, 1'b1, 3, 32'h11223344, 4'b0101); step();
    req(1'b1, 1'b0, 3, 32'h0, 4'h0); step();
    check("be_rdata", rdata0, 32'hAA22CC44);
    check("be_rvalid", 32'(rv0), 32'h1);
    req(1'b0, 1'b1, 3, 32'hFFFFFFFF, 4'b0000); step();
    req(1'b1, 1'b0, 3, 32'h0, 4'h0); step();
    check("be0_noop", rdata0, 32'hAA22CC44);
    idle(6);

    // Three wait states; request held through Busy.
    req(1'b0, 1'b1, 63, 32'hDEADBEEF, 4'b1111);
    step(); check("w3_busy_a", 32'(busy3), 32'h1);
    step(); check("w3_busy_b", 32'(busy3), 32'h1);
    step(); check("w3_busy_c", 32'(busy3), 32'h1);
    step(); check("w3_busy_end", 32'(busy3), 32'h0);
    req(1'b1, 1'b0, 63, 32'h0, 4'h0);
    step(); check("r3_busy_a", 32'(busy3), 32'h1); check("r3_rv_a", 32'(rv3), 32'h0);
    step(); check("r3_busy_b", 32'(busy3), 32'h1); check("r3_rv_b", 32'(rv3), 32'h0);
    step(); check("r3_busy_c", 32'(busy3), 32'h1); check("r3_rv_c", 32'(rv3), 32'h0);
    step();
    check("r3_busy_end", 32'(busy3), 32'h0);
    check("r3_rvalid", 32'(rv3), 32'h1);
    check("r3_rdata", rdata3, 32'hDEADBEEF);
    rd = 1'b0;
    step();
    check("r3_pulse", 32'(rv3), 32'h0);
    check("r3_no_reaccept", 32'(busy3), 32'h0);
    idle(8);

    // Read and write in one request at latency 2.
    req(1'b0, 1'b1, 10, 32'h1, 4'b1111); step();
    idle(4);
    req(1'b1, 1'b1, 10, 32'h2, 4'b1111); step();
    check("rw_busy", 32'(busy2), 32'h1);
    idle(1);
    check("rw_early", 32'(rv2), 32'h0);
    step();
    check("rw_rvalid", 32'(rv2), 32'h1);
    check("rw_old", rdata2, 32'h1);
    req(1'b1, 1'b0, 10, 32'h0, 4'h0); step();
    idle(2);
    check("rw_new_rv", 32'(rv2), 32'h1);
    check("rw_new", rdata2, 32'h2);
    idle(6);

    // Reset in the second WAIT cycle cancels a pending write at latency 4.
    req(1'b0, 1'b1, 7, 32'h5, 4'b1111); step();
    idle(6);
    req(1'b0, 1'b1, 7, 32'h9, 4'b1111); step();
    check("rw4_busy", 32'(busy4), 32'h1);
    idle(1);
    reset = 1'b1;
    step();
    check("rw4_rst_busy", 32'(busy4), 32'h0);
    check("rw4_rst_rv", 32'(rv4), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rw4_no_rv", 32'(rv4), 32'h0);
    end
    req(1'b1, 1'b0, 7, 32'h0, 4'h0); step();
    idle(4);
    check("rw4_read_rv", 32'(rv4), 32'h1);
    check("rw4_read", rdata4, 32'h5);
    idle(6);

    // Back-to-back at zero latency across the whole array.
    for (int a = 0; a < 64; a++) begin
      req(1'b0, 1'b1, a, 32'(a * 3), 4'b1111);
      step();
    end
    for (int a = 0; a < 64; a++) begin
      req(1'b1, 1'b0, a, 32'h0, 4'h0);
      step();
      check("b2b_rdata", rdata0, 32'(a * 3));
      check("b2b_rvalid", 32'(rv0), 32'h1);
    end
    idle(1);
    check("b2b_end_rv", 32'(rv0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
